// File: rtl/jpeg_frame_sched.sv
// jpeg_frame_sched: admits the upstream JPEG byte stream into jpeg_core one
// frame at a time. Completion is declared from the pixel output handshake.
// A stall watchdog aborts a hung frame, flushes the core and drops the rest
// of that frame so that the next one starts clean.
module jpeg_frame_sched #(
  parameter int TIMEOUT_W    = 24,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_enable_i,
  input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
  input  logic                 src_valid_i,
  input  logic [31:0]          src_data_i,
  input  logic [3:0]           src_strb_i,
  input  logic                 src_last_i,
  output logic                 src_accept_o,
  output logic                 core_valid_o,
  output logic [31:0]          core_data_o,
  output logic [3:0]           core_strb_o,
  output logic                 core_last_o,
  input  logic                 core_accept_i,
  input  logic                 core_idle_i,
  input  logic                 pix_valid_i,
  input  logic                 pix_accept_i,
  input  logic [15:0]          img_width_i,
  input  logic [15:0]          img_height_i,
  output logic                 core_rst_o,
  output logic                 busy_o,
  output logic                 frame_start_o,
  output logic                 frame_done_o,
  output logic                 frame_error_o,
  output logic [15:0]          frame_count_o,
  output logic [31:0]          pix_count_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FEED    = 3'd1;
  localparam logic [2:0] ST_DRAIN   = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_FLUSH   = 3'd4;
  localparam logic [2:0] ST_DISCARD = 3'd5;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  logic [2:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [3:0]           flush_cnt_q, flush_cnt_d;
  logic                 pending_discard_q, pending_discard_d;
  logic                 started_q, started_d;
  logic [31:0]          exp_q, exp_d;
  logic                 exp_valid_q, exp_valid_d;
  logic [31:0]          pix_cnt_q, pix_cnt_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;

  logic        src_hs;
  logic        core_hs;
  logic        pix_hs;
  logic        in_frame;
  logic        timeout;
  logic        overrun;
  logic [31:0] exp_now;

  // Stream routing: pass-through while feeding, sink-everything while discarding.
  always_comb begin
    src_accept_o = 1'b0;
    core_valid_o = 1'b0;
    core_data_o  = '0;
    core_strb_o  = '0;
    core_last_o  = 1'b0;
    case (state_q)
      ST_FEED: begin
        core_valid_o = src_valid_i;
        core_data_o  = src_data_i;
        core_strb_o  = src_strb_i;
        core_last_o  = src_last_i;
        src_accept_o = core_accept_i;
      end
      ST_DISCARD: src_accept_o = 1'b1;
      default: ;
    endcase
  end

  assign src_hs   = src_valid_i & src_accept_o;
  assign core_hs  = core_valid_o & core_accept_i;
  assign pix_hs   = pix_valid_i & pix_accept_i;
  assign in_frame = (state_q == ST_FEED) || (state_q == ST_DRAIN);

  // Before the first pixel the live geometry is used, so a zero-sized image
  // flags its very first pixel as an overrun.
  assign exp_now  = exp_valid_q ? exp_q : (32'(img_width_i) * 32'(img_height_i));
  assign overrun  = in_frame && pix_hs && (pix_cnt_q == exp_now);
  assign timeout  = (cfg_timeout_i != '0) && (wd_q >= cfg_timeout_i);

  assign frame_start_o = (state_q == ST_FEED) && src_hs && !started_q;
  assign frame_done_o  = (state_q == ST_DONE);
  assign frame_error_o = ((state_q == ST_FLUSH) && (flush_cnt_q == '0)) || overrun;
  assign core_rst_o    = (state_q == ST_FLUSH);
  assign busy_o        = (state_q != ST_IDLE);
  assign frame_count_o = frame_cnt_q;
  assign pix_count_o   = pix_cnt_q;

  // Frame sequencing, pixel accounting and the stall watchdog.
  always_comb begin
    state_d           = state_q;
    flush_cnt_d       = flush_cnt_q;
    pending_discard_d = pending_discard_q;
    started_d         = started_q;
    exp_d             = exp_q;
    exp_valid_d       = exp_valid_q;
    pix_cnt_d         = pix_cnt_q;
    frame_cnt_d       = frame_cnt_q;
    wd_d              = '0;

    if (in_frame && pix_hs) begin
      if (!exp_valid_q) begin
        exp_d       = exp_now;
        exp_valid_d = 1'b1;
      end
      if (!overrun && (pix_cnt_q != 32'hFFFF_FFFF)) begin
        pix_cnt_d = pix_cnt_q + 32'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_enable_i && src_valid_i) begin
          state_d     = ST_FEED;
          pix_cnt_d   = '0;
          exp_valid_d = 1'b0;
          started_d   = 1'b0;
        end
      end
      ST_FEED: begin
        if (src_hs) begin
          started_d = 1'b1;
        end
        // A last-word handshake beats a simultaneous timeout.
        if (src_hs && src_last_i) begin
          state_d = ST_DRAIN;
        end else if (timeout) begin
          state_d           = ST_FLUSH;
          flush_cnt_d       = '0;
          pending_discard_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (exp_valid_q && (pix_cnt_q == exp_q) && core_idle_i) begin
          state_d = ST_DONE;
        end else if (timeout) begin
          state_d           = ST_FLUSH;
          flush_cnt_d       = '0;
          pending_discard_d = 1'b0;
        end
      end
      ST_DONE: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = ST_IDLE;
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q + 4'd1;
        if (flush_cnt_q == FLUSH_LAST) begin
          flush_cnt_d = '0;
          state_d     = pending_discard_q ? ST_DISCARD : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (src_hs && src_last_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any sign of life or any state change restarts the stall count.
    if (in_frame && !(src_hs || core_hs || pix_hs || (state_d != state_q))) begin
      wd_d = (wd_q == '1) ? wd_q : wd_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= ST_IDLE;
      wd_q              <= '0;
      flush_cnt_q       <= '0;
      pending_discard_q <= 1'b0;
      started_q         <= 1'b0;
      exp_q             <= '0;
      exp_valid_q       <= 1'b0;
      pix_cnt_q         <= '0;
      frame_cnt_q       <= '0;
    end else begin
      state_q           <= state_d;
      wd_q              <= wd_d;
      flush_cnt_q       <= flush_cnt_d;
      pending_discard_q <= pending_discard_d;
      started_q         <= started_d;
      exp_q             <= exp_d;
      exp_valid_q       <= exp_valid_d;
      pix_cnt_q         <= pix_cnt_d;
      frame_cnt_q       <= frame_cnt_d;
    end
  end

endmodule

// File: doc/jpeg_frame_sched.md
Name: jpeg_frame_sched

Overview:
Frame-level sequencer placed in front of jpeg_core. It gates the 32-bit JPEG byte stream from the upstream source into the core one frame at a time. It monitors the core's pixel output handshake and declares the frame complete once all width*height pixels have left and the core reports idle. A watchdog detects stalled frames; on a stall the block resets the core and discards the remainder of the offending frame so the next frame starts clean.

Parameters:
TIMEOUT_W, 24, width of the watchdog counter and of cfg_timeout_i.
FLUSH_CYCLES, 4, number of cycles core_rst_o is held high on abort (1..15).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cfg_enable_i  in  1  allow new frames to start
cfg_timeout_i  in  TIMEOUT_W  stall limit in cycles; 0 disables the watchdog
src_valid_i  in  1  upstream stream valid
src_data_i  in  32  upstream data
src_strb_i  in  4  upstream byte strobes
src_last_i  in  1  last word of frame
src_accept_o  out  1  upstream accept
core_valid_o  out  1  to jpeg_core inport_valid_i
core_data_o  out  32  to jpeg_core inport_data_i
core_strb_o  out  4  to jpeg_core inport_strb_i
core_last_o  out  1  to jpeg_core inport_last_i
core_accept_i  in  1  from jpeg_core inport_accept_o
core_idle_i  in  1  from jpeg_core idle_o
pix_valid_i  in  1  jpeg_core outport_valid_o (monitor only)
pix_accept_i  in  1  sink outport_accept_i (monitor only)
img_width_i  in  16  jpeg_core outport_width_o
img_height_i  in  16  jpeg_core outport_height_o
core_rst_o  out  1  core soft reset; ORed with rst_i at top level
busy_o  out  1  state != IDLE
frame_start_o  out  1  one-cycle pulse on first accepted word of a frame
frame_done_o  out  1  one-cycle pulse on good completion
frame_error_o  out  1  one-cycle pulse on abort or pixel overrun
frame_count_o  out  16  completed good frames, wraps at 0xFFFF->0
pix_count_o  out  32  pixels handshaken in the current/last frame

Behaviour:
- Reset: state=IDLE; all outputs 0; counters cleared. Reset mid-frame returns to IDLE without discard; upstream must also be reset.
- Pixel handshake = pix_valid_i & pix_accept_i. Expected count E = img_width_i*img_height_i (32-bit), sampled on the first pixel handshake of the frame.
- Watchdog: counter clears on any src or core handshake, any pixel handshake, and on every state change; otherwise it increments in FEED/DRAIN. When cfg_timeout_i != 0 and the counter reaches cfg_timeout_i, the block aborts.
- IDLE: src_accept_o=0, core_valid_o=0. If cfg_enable_i & src_valid_i -> FEED; pix_count clears on the same edge.
- FEED: combinational pass-through. core_valid/data/strb/last = src_*; src_accept_o = core_accept_i. frame_start_o pulses on the first handshake. A handshake with src_last_i=1 -> DRAIN. Timeout -> FLUSH with pending_discard=1.
- DRAIN: src_accept_o=0, core_valid_o=0. When pix_count==E (E sampled) and core_idle_i=1 -> DONE. Timeout -> FLUSH with pending_discard=0.
- DONE (1 cycle): frame_done_o=1, frame_count+1 -> IDLE.
- FLUSH: core_rst_o=1 for exactly FLUSH_CYCLES cycles; frame_error_o pulses in the first FLUSH cycle. Then go to DISCARD if pending_discard=1, else IDLE.
- DISCARD: src_accept_o=1, core_valid_o=0. Words are dropped until a handshake with src_last_i=1 -> IDLE. The watchdog is not active here.
- Pixel overrun: a pixel handshake when pix_count==E pulses frame_error_o and does not increment pix_count. State is unaffected.
- pix_count_o saturates at 0xFFFFFFFF and holds its value through IDLE until the next frame starts.
- cfg_enable_i deasserted mid-frame has no effect until the block returns to IDLE.
- If the timeout fires in the same cycle as a src_last handshake, the handshake wins (-> DRAIN).

Test Plan:
- 16x8 frame of 40 words, sink always accepting -> frame_start_o once, exactly 40 core handshakes, 128 pixel handshakes, frame_done_o one cycle after core_idle_i, frame_count_o=1.
- Two back-to-back frames with src_valid_i held high -> second frame_start_o appears only after first frame_done_o; no src_accept_o in DRAIN/DONE; frame_count_o=2.
- cfg_timeout_i=100, core_accept_i held 0 mid-frame -> after 100 stall cycles: frame_error_o pulse, core_rst_o high exactly 4 cycles, remaining words accepted and dropped through src_last, then IDLE; frame_count_o unchanged.
- cfg_timeout_i=50, image 8x8 where only 60 pixels emerge -> DRAIN times out, FLUSH then IDLE with no DISCARD; pix_count_o=60.
- Extra pixel handshake after 64/64 for 8x8 -> frame_error_o pulse, pix_count_o stays 64, frame still completes with frame_done_o.
- cfg_timeout_i=0 with a 10k-cycle stall -> no abort; rst_i asserted mid-FEED -> all outputs 0 next cycle, state IDLE.
